// File: rtl/word_deserializer.sv
// -----------------------------------------------------------------------------
// word_deserializer
//   Serial-to-parallel stage for the CNN datapath. Collects NUM_WORDS signed
//   words from an upstream valid/ready producer and presents them as one packed
//   vector to a downstream parallel consumer. A new word can be accepted in the
//   same cycle the full vector is drained, so streaming runs at one word per
//   cycle with no bubble between vectors.
//
// Ports
//   clk_i    : clock, all state updates on the rising edge
//   reset_i  : synchronous, active-high reset
//   ready_o  : this block can accept a word (combinational from ready_i when full)
//   valid_i  : data_i carries a valid word
//   data_i   : incoming signed word
//   valid_o  : data_o holds a complete vector (registered)
//   ready_i  : downstream accepts the vector
//   data_o   : packed vector, word k at [(k+1)*WORD_SIZE-1 : k*WORD_SIZE],
//              word 0 is the first word received (registered)
// -----------------------------------------------------------------------------

// Protocol checker: a full vector never coexists with a partial count, and a
// presented vector is only withdrawn by a drain handshake or by reset.
module word_deserializer_chk (
    input logic clk_i,
    input logic reset_i,
    input logic valid_o,
    input logic ready_i,
    input logic count_nz
);

    // Full and partially filled are mutually exclusive.
    a_full_has_zero_count: assert property (
        @(posedge clk_i) disable iff (reset_i) !(valid_o && count_nz)
    );

    // valid_o only falls after a drain handshake or a reset edge.
    a_valid_held: assert property (
        @(posedge clk_i) ($past(valid_o) && !valid_o) |-> $past(reset_i || ready_i)
    );

endmodule

module word_deserializer #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_WORDS = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    output logic                           ready_o,
    input  logic                           valid_i,
    input  logic [WORD_SIZE-1:0]           data_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [NUM_WORDS*WORD_SIZE-1:0] data_o
);

    localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t                         state_r;
    logic [CW-1:0]                  count_r;
    logic                           valid_r;
    logic [NUM_WORDS*WORD_SIZE-1:0] data_r;

    logic ready_s;
    logic in_hs_s;
    logic out_hs_s;

    // Accept readiness: always ready while filling; when full, a word can only
    // enter if the pending vector leaves on the same edge.
    always_comb begin
        ready_s = 1'b1;
        case (state_r)
            ST_FILL: ready_s = 1'b1;
            ST_FULL: ready_s = ready_i;
            default: ready_s = 1'b1;
        endcase
        in_hs_s  = valid_i & ready_s;
        out_hs_s = valid_r & ready_i;
    end

    assign ready_o = ready_s;
    assign valid_o = valid_r;
    assign data_o  = data_r;

    // Fill/drain state machine with the word slots kept in the output register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_FILL;
            count_r <= {CW{1'b0}};
            valid_r <= 1'b0;
            data_r  <= {(NUM_WORDS*WORD_SIZE){1'b0}};
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (in_hs_s) begin
                        for (int k = 0; k < NUM_WORDS; k++) begin
                            if (count_r == CW'(k)) begin
                                data_r[k*WORD_SIZE +: WORD_SIZE] <= data_i;
                            end
                        end
                        if (count_r == LAST_IDX) begin
                            count_r <= {CW{1'b0}};
                            state_r <= ST_FULL;
                            valid_r <= 1'b1;
                        end else begin
                            count_r <= count_r + CW'(1);
                        end
                    end
                end
                ST_FULL: begin
                    if (out_hs_s) begin
                        if (valid_i) begin
                            // Vector drains and the incoming word becomes slot 0
                            // of the next one on the same edge.
                            data_r[WORD_SIZE-1:0] <= data_i;
                            if (NUM_WORDS > 1) begin
                                count_r <= CW'(1);
                                state_r <= ST_FILL;
                                valid_r <= 1'b0;
                            end else begin
                                count_r <= {CW{1'b0}};
                                state_r <= ST_FULL;
                                valid_r <= 1'b1;
                            end
                        end else begin
                            count_r <= {CW{1'b0}};
                            state_r <= ST_FILL;
                            valid_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_FILL;
                    count_r <= {CW{1'b0}};
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    word_deserializer_chk u_chk (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .valid_o  (valid_r),
        .ready_i  (ready_i),
        .count_nz (count_r != {CW{1'b0}})
    );

endmodule

// File: tb/tb_word_deserializer.sv
// -----------------------------------------------------------------------------
// tb_word_deserializer
//   Scoreboard bench. A reference model groups accepted words into vectors and
//   queues the expected packed result; a monitor compares data_o against the
//   queue head whenever a vector is presented and pops it on drain. A second
//   instance with NUM_WORDS=1 gets a short directed check.
// -----------------------------------------------------------------------------
module tb_word_deserializer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i;
    logic        valid_i, ready_i, ready_o, valid_o;
    logic [15:0] data_i;
    logic [63:0] data_o;

    logic        v1_i, r1_i, ready1_o, valid1_o;
    logic [15:0] d1_i, d1_o;

    int checks   = 0;
    int failures = 0;

    logic [63:0] expq[$];
    logic [15:0] part[$];
    bit          m_full  = 1'b0;
    bit          started = 1'b0;

    word_deserializer #(.WORD_SIZE(16), .NUM_WORDS(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .ready_o(ready_o), .valid_i(valid_i),
        .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
    );

    word_deserializer #(.WORD_SIZE(16), .NUM_WORDS(1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .ready_o(ready1_o), .valid_i(v1_i),
        .data_i(d1_i), .valid_o(valid1_o), .ready_i(r1_i), .data_o(d1_o)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endfunction

    // Reference model: at each edge, a pending vector leaves if ready_i, and a
    // word is accepted if valid and there is room (or room is made this edge).
    initial begin
        logic [63:0] vec;
        bit          acc;
        forever begin
            @(posedge clk);
            if (reset_i) begin
                m_full = 1'b0;
                part.delete();
                expq.delete();
            end else begin
                acc = valid_i && (!m_full || ready_i);
                if (m_full && ready_i) m_full = 1'b0;
                if (acc) begin
                    part.push_back(data_i);
                    if (part.size() == 4) begin
                        vec = 64'd0;
                        for (int i = 0; i < 4; i++) vec = vec | (64'(part[i]) << (16 * i));
                        expq.push_back(vec);
                        part.delete();
                        m_full = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: handshake flags every cycle, vector contents whenever presented.
    initial begin
        forever begin
            @(negedge clk);
            if (started && !reset_i) begin
                check("valid_o", 64'(valid_o), 64'(m_full));
                check("ready_o", 64'(ready_o), 64'(!m_full || ready_i));
                if (valid_o) begin
                    if (expq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL data_o: got %h expected no vector at %0t", data_o, $time);
                    end else begin
                        check("data_o", data_o, expq[0]);
                        if (ready_i) void'(expq.pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [15:0] d, input logic r);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    // Offer one word, holding it until accepted, with random downstream ready.
    task automatic send(input logic [15:0] d, input int rp);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        valid_i = 1'b1;
        data_i  = d;
        while (!acc && n < 100) begin
            ready_i = ($urandom_range(0, 99) < rp);
            @(negedge clk);
            acc = (!m_full || ready_i);
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout: got not accepted expected accepted for %h", d);
        end
    endtask

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] pat;
        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = 16'h0000;
        v1_i = 1'b0; r1_i = 1'b0; d1_i = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        started = 1'b1;
        check("rst_data", data_o, 64'h0);
        check("rst_valid", 64'(valid_o), 64'h0);
        check("rst_ready", 64'(ready_o), 64'h1);

        // Basic fill
        cyc(1'b1, 16'h0001, 1'b1);
        cyc(1'b1, 16'hFFFF, 1'b1);
        cyc(1'b1, 16'h8000, 1'b1);
        cyc(1'b1, 16'h7FFF, 1'b1);
        check("basic_valid", 64'(valid_o), 64'h1);
        check("basic_vec", data_o, 64'h7FFF_8000_FFFF_0001);
        cyc(1'b0, 16'h0000, 1'b1);
        check("basic_drop", 64'(valid_o), 64'h0);

        // Backpressure with a word waiting upstream
        for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(16'h0010 + i), 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 16'h1234, 1'b0);
            check("bp_hold", data_o, 64'h0014_0013_0012_0011);
        end
        cyc(1'b1, 16'h1234, 1'b1);
        check("bp_drain", 64'(valid_o), 64'h0);
        cyc(1'b1, 16'h0021, 1'b1);
        cyc(1'b1, 16'h0022, 1'b1);
        cyc(1'b1, 16'h0023, 1'b1);
        check("bp_next_vec", data_o, 64'h0023_0022_0021_1234);
        cyc(1'b0, 16'h0000, 1'b1);

        // Streaming 1..12
        for (int i = 1; i <= 12; i++) cyc(1'b1, 16'(i), 1'b1);
        check("stream_last", data_o, 64'h000C_000B_000A_0009);
        cyc(1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 16'h0000, 1'b1);

        // Gappy input 1,0,0,1,0,1,1
        pat = 7'b1101001;
        for (int i = 0; i < 7; i++) cyc(pat[i], 16'(16'h00A0 + i), 1'b1);
        check("gap_valid", 64'(valid_o), 64'h1);
        check("gap_vec", data_o, 64'h00A6_00A5_00A3_00A0);
        cyc(1'b0, 16'h0000, 1'b1);

        // Reset mid-fill
        cyc(1'b1, 16'h0055, 1'b1);
        cyc(1'b1, 16'h0066, 1'b1);
        do_reset();
        cyc(1'b1, 16'h000A, 1'b1);
        cyc(1'b1, 16'h000B, 1'b1);
        cyc(1'b1, 16'h000C, 1'b1);
        cyc(1'b1, 16'h000D, 1'b1);
        check("rstmid_vec", data_o, 64'h000D_000C_000B_000A);
        cyc(1'b0, 16'h0000, 1'b1);

        // Reset while full
        for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h0B00 + i), 1'b1);
        cyc(1'b0, 16'h0000, 1'b0);
        do_reset();
        check("rstfull_valid", 64'(valid_o), 64'h0);
        check("rstfull_data", data_o, 64'h0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) cyc(1'b0, 16'($urandom), 1'($urandom_range(0, 1)));
            send(16'($urandom), 60);
        end
        valid_i = 1'b0;
        repeat (3) cyc(1'b0, 16'h0000, 1'b1);
        check("sb_empty", 64'(expq.size()), 64'h0);

        // NUM_WORDS=1 instance: continuous words 5,6,7
        check("n1_ready_idle", 64'(ready1_o), 64'h1);
        r1_i = 1'b1;
        v1_i = 1'b1;
        for (int i = 5; i <= 7; i++) begin
            d1_i = 16'(i);
            @(posedge clk);
            #1;
            check("n1_valid", 64'(valid1_o), 64'h1);
            check("n1_data", 64'(d1_o), 64'(i));
            check("n1_ready", 64'(ready1_o), 64'h1);
        end
        v1_i = 1'b0;
        @(posedge clk);
        #1;
        check("n1_drop", 64'(valid1_o), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/word_deserializer.md
Name: word_deserializer

Overview:
- Serial-to-parallel layer for the CNN datapath. Collects NUM_WORDS sequential signed words from an upstream valid-ready producer, such as a layer that emits one word per handshake.
- Presents the collected words as one packed vector to a downstream parallel consumer, such as a dense or conv stage.
- Helpful producer and consumer: accepts a new word in the same cycle a full vector is drained.
- data_o comes directly from a register.

Parameters:
- WORD_SIZE, 16: bits per word, signed.
- NUM_WORDS, 4: words per output vector, ≥1.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- reset_i  input  1  reset; synchronous, active-high.
- ready_o  output  1  handshake to prev layer: this block can accept a word.
- valid_i  input  1  handshake to prev layer: data_i is valid.
- data_i  input  WORD_SIZE  handshake to prev layer: incoming signed word, driven from a register.
- valid_o  output  1  handshake to next layer: data_o holds a complete vector.
- ready_i  input  1  handshake to next layer: next layer accepts the vector.
- data_o  output  NUM_WORDS*WORD_SIZE  packed vector. Word k occupies bits [(k+1)*WORD_SIZE-1 : k*WORD_SIZE]. Word 0 is the first word received.

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values (next edge with reset_i=1):
  - count=0, state=FILL, valid_o=0, data_o=0.
  - ready_o=1 in the cycle after reset deasserts.
  - Reset mid-fill discards partial words.
  - Reset while FULL drops the pending vector; valid_o=0 next cycle.
- Handshakes:
  - In = valid_i & ready_o.
  - Out = valid_o & ready_i.
  - Transfers occur only on posedge.
- State FILL (valid_o=0, ready_o=1):
  - On In: slot[count] <= data_i, count <= count+1.
  - If count==NUM_WORDS-1: count <= 0, go to FULL.
  - No In: hold all state.
- State FULL (valid_o=1, ready_o=ready_i, combinational pass-through):
  - Out & !valid_i: go to FILL, count=0.
  - Out & valid_i (simultaneous):
    - vector consumed; slot[0] <= data_i.
    - NUM_WORDS>1: count=1, go to FILL.
    - NUM_WORDS==1: stay FULL with the new word.
  - !ready_i: hold; data_o stable; ready_o=0 (backpressure).
- Stale slots:
  - Slots not yet overwritten retain old contents while in FILL.
  - valid_o=0 during FILL, so the downstream stage must not sample data_o then.
- Latency: valid_o rises on the edge that captures the NUM_WORDS-th word, i.e. visible the cycle after that handshake.
- Throughput: 1 word/cycle sustained when ready_i is held high. No bubble between vectors.
- Arithmetic: none. Words are copied bit-exact, signedness preserved.
- count width: $clog2(NUM_WORDS), minimum 1 bit. count never exceeds NUM_WORDS-1.
- valid_i with ready_o=0: ignored. Upstream must hold data_i until accepted.
- Assertions the implementation must satisfy:
  - valid_o and count≠0 never both true.
  - valid_o is never dropped without Out or reset.

Test Plan (WORD_SIZE=16, NUM_WORDS=4 unless stated):
- Basic fill, ready_i=1:
  - Stimulus: send 0x0001, 0xFFFF, 0x8000, 0x7FFF on consecutive cycles.
  - Response: valid_o=1 one cycle after the 4th handshake, data_o=0x7FFF_8000_FFFF_0001.
  - Then valid_o=0 next cycle.
- Backpressure:
  - Stimulus: ready_i=0 after vector full; offer 0x1234 on valid_i for 5 cycles.
  - Response: ready_o=0, data_o unchanged, valid_o=1 throughout.
  - On ready_i=1: 0x1234 captured in slot 0 the same edge the vector drains; count=1.
- Streaming:
  - Stimulus: 12 words 1..12 with valid_i=1 and ready_i=1 every cycle.
  - Response: three vectors 0x0004_0003_0002_0001, 0x0008_..._0005, 0x000C_..._0009, with zero idle cycles.
- Gappy input:
  - Stimulus: valid_i pattern 1,0,0,1,0,1,1.
  - Response: vector completes only on the 4th accepted word; count advances only on handshakes.
- Reset mid-operation:
  - Stimulus: assert reset_i after 2 words; release; send 0xA,0xB,0xC,0xD.
  - Response: data_o=0x000D_000C_000B_000A; pre-reset words absent.
  - Variant: reset while FULL gives valid_o=0 next cycle.
- NUM_WORDS=1:
  - Stimulus: continuous valid_i and ready_i with words 5,6,7.
  - Response: valid_o stays 1 after the first word; data_o=5,6,7 on consecutive cycles; ready_o=1 throughout.
